// File: rtl/tl_buffer_ad_if.sv
// TileLink A/D channel bundle for tl_buffer_ad.
// The slave view belongs to the buffer: it receives upstream A and downstream D,
// and drives downstream A and upstream D. The master view is its environment.
interface tl_buffer_ad_if;
    // Upstream A channel (into the buffer)
    logic        auto_in_a_valid;
    logic        auto_in_a_ready;
    logic [2:0]  auto_in_a_bits_opcode;
    logic [2:0]  auto_in_a_bits_param;
    logic [3:0]  auto_in_a_bits_size;
    logic [4:0]  auto_in_a_bits_source;
    logic [30:0] auto_in_a_bits_address;
    logic [7:0]  auto_in_a_bits_mask;
    logic [63:0] auto_in_a_bits_data;
    logic        auto_in_a_bits_corrupt;

    // Downstream A channel (out of the buffer)
    logic        auto_out_a_valid;
    logic        auto_out_a_ready;
    logic [2:0]  auto_out_a_bits_opcode;
    logic [2:0]  auto_out_a_bits_param;
    logic [3:0]  auto_out_a_bits_size;
    logic [4:0]  auto_out_a_bits_source;
    logic [30:0] auto_out_a_bits_address;
    logic [7:0]  auto_out_a_bits_mask;
    logic [63:0] auto_out_a_bits_data;
    logic        auto_out_a_bits_corrupt;

    // Downstream D channel (into the buffer)
    logic        auto_out_d_valid;
    logic        auto_out_d_ready;
    logic [2:0]  auto_out_d_bits_opcode;
    logic [1:0]  auto_out_d_bits_param;
    logic [3:0]  auto_out_d_bits_size;
    logic [4:0]  auto_out_d_bits_source;
    logic        auto_out_d_bits_sink;
    logic        auto_out_d_bits_denied;
    logic [63:0] auto_out_d_bits_data;
    logic        auto_out_d_bits_corrupt;

    // Upstream D channel (out of the buffer)
    logic        auto_in_d_valid;
    logic        auto_in_d_ready;
    logic [2:0]  auto_in_d_bits_opcode;
    logic [1:0]  auto_in_d_bits_param;
    logic [3:0]  auto_in_d_bits_size;
    logic [4:0]  auto_in_d_bits_source;
    logic        auto_in_d_bits_sink;
    logic        auto_in_d_bits_denied;
    logic [63:0] auto_in_d_bits_data;
    logic        auto_in_d_bits_corrupt;

    modport slave (
        input  auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_param,
               auto_in_a_bits_size, auto_in_a_bits_source, auto_in_a_bits_address,
               auto_in_a_bits_mask, auto_in_a_bits_data, auto_in_a_bits_corrupt,
        output auto_in_a_ready,
        output auto_out_a_valid, auto_out_a_bits_opcode, auto_out_a_bits_param,
               auto_out_a_bits_size, auto_out_a_bits_source, auto_out_a_bits_address,
               auto_out_a_bits_mask, auto_out_a_bits_data, auto_out_a_bits_corrupt,
        input  auto_out_a_ready,
        input  auto_out_d_valid, auto_out_d_bits_opcode, auto_out_d_bits_param,
               auto_out_d_bits_size, auto_out_d_bits_source, auto_out_d_bits_sink,
               auto_out_d_bits_denied, auto_out_d_bits_data, auto_out_d_bits_corrupt,
        output auto_out_d_ready,
        output auto_in_d_valid, auto_in_d_bits_opcode, auto_in_d_bits_param,
               auto_in_d_bits_size, auto_in_d_bits_source, auto_in_d_bits_sink,
               auto_in_d_bits_denied, auto_in_d_bits_data, auto_in_d_bits_corrupt,
        input  auto_in_d_ready
    );

    modport master (
        output auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_param,
               auto_in_a_bits_size, auto_in_a_bits_source, auto_in_a_bits_address,
               auto_in_a_bits_mask, auto_in_a_bits_data, auto_in_a_bits_corrupt,
        input  auto_in_a_ready,
        input  auto_out_a_valid, auto_out_a_bits_opcode, auto_out_a_bits_param,
               auto_out_a_bits_size, auto_out_a_bits_source, auto_out_a_bits_address,
               auto_out_a_bits_mask, auto_out_a_bits_data, auto_out_a_bits_corrupt,
        output auto_out_a_ready,
        output auto_out_d_valid, auto_out_d_bits_opcode, auto_out_d_bits_param,
               auto_out_d_bits_size, auto_out_d_bits_source, auto_out_d_bits_sink,
               auto_out_d_bits_denied, auto_out_d_bits_data, auto_out_d_bits_corrupt,
        input  auto_out_d_ready,
        input  auto_in_d_valid, auto_in_d_bits_opcode, auto_in_d_bits_param,
               auto_in_d_bits_size, auto_in_d_bits_source, auto_in_d_bits_sink,
               auto_in_d_bits_denied, auto_in_d_bits_data, auto_in_d_bits_corrupt,
        output auto_in_d_ready
    );
endinterface

// File: rtl/tl_buffer_ad.sv
// TileLink A/D buffer: one independent circular-buffer queue per channel.
// Handshakes are driven purely from the registered occupancy, so there is no
// combinational path from any input to any output handshake (no flow/pipe-through).

// Generic registered queue used for both channels.
module tl_buffer_ad_queue #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_bits,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_bits
);
    logic [2:0]        enq_ptr;
    logic [2:0]        deq_ptr;
    logic [3:0]        count;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              do_enq;
    logic              do_deq;

    // Ready/valid come only from the registered count: a full queue refuses
    // input even while it is draining, and an empty queue never forwards input.
    assign in_ready  = (count != 4'(DEPTH));
    assign out_valid = (count != 4'd0);
    assign do_enq    = in_valid && in_ready;
    assign do_deq    = out_valid && out_ready;

    function automatic logic [2:0] next_ptr(input logic [2:0] ptr);
        return (ptr == 3'(DEPTH - 1)) ? 3'd0 : ptr + 3'd1;
    endfunction

    // Pointer and occupancy control; reset discards every queued beat at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enq_ptr <= 3'd0;
            deq_ptr <= 3'd0;
            count   <= 4'd0;
        end else begin
            if (do_enq) enq_ptr <= next_ptr(enq_ptr);
            if (do_deq) deq_ptr <= next_ptr(deq_ptr);
            case ({do_enq, do_deq})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage is deliberately left unreset; it is only observed while valid.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (do_enq && (enq_ptr == 3'(i))) mem[i] <= in_bits;
        end
    end

    // Head-of-queue select; stays put while the consumer stalls.
    always_comb begin
        out_bits = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (deq_ptr == 3'(i)) out_bits = mem[i];
        end
    end
endmodule

module tl_buffer_ad #(
    parameter int A_DEPTH = 2,
    parameter int D_DEPTH = 2
) (
    input logic         clock,
    input logic         reset,
    tl_buffer_ad_if.slave bus
);
    localparam int A_W = 119;
    localparam int D_W = 81;

    logic [A_W-1:0] a_in_bits;
    logic [A_W-1:0] a_out_bits;
    logic [D_W-1:0] d_in_bits;
    logic [D_W-1:0] d_out_bits;

    // Flatten each channel's fields so the queue carries them bit-exact.
    assign a_in_bits = {bus.auto_in_a_bits_opcode, bus.auto_in_a_bits_param,
                        bus.auto_in_a_bits_size, bus.auto_in_a_bits_source,
                        bus.auto_in_a_bits_address, bus.auto_in_a_bits_mask,
                        bus.auto_in_a_bits_data, bus.auto_in_a_bits_corrupt};

    assign {bus.auto_out_a_bits_opcode, bus.auto_out_a_bits_param,
            bus.auto_out_a_bits_size, bus.auto_out_a_bits_source,
            bus.auto_out_a_bits_address, bus.auto_out_a_bits_mask,
            bus.auto_out_a_bits_data, bus.auto_out_a_bits_corrupt} = a_out_bits;

    assign d_in_bits = {bus.auto_out_d_bits_opcode, bus.auto_out_d_bits_param,
                        bus.auto_out_d_bits_size, bus.auto_out_d_bits_source,
                        bus.auto_out_d_bits_sink, bus.auto_out_d_bits_denied,
                        bus.auto_out_d_bits_data, bus.auto_out_d_bits_corrupt};

    assign {bus.auto_in_d_bits_opcode, bus.auto_in_d_bits_param,
            bus.auto_in_d_bits_size, bus.auto_in_d_bits_source,
            bus.auto_in_d_bits_sink, bus.auto_in_d_bits_denied,
            bus.auto_in_d_bits_data, bus.auto_in_d_bits_corrupt} = d_out_bits;

    tl_buffer_ad_queue #(
        .DEPTH  (A_DEPTH),
        .DATA_W (A_W)
    ) a_queue (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (bus.auto_in_a_valid),
        .in_ready  (bus.auto_in_a_ready),
        .in_bits   (a_in_bits),
        .out_valid (bus.auto_out_a_valid),
        .out_ready (bus.auto_out_a_ready),
        .out_bits  (a_out_bits)
    );

    tl_buffer_ad_queue #(
        .DEPTH  (D_DEPTH),
        .DATA_W (D_W)
    ) d_queue (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (bus.auto_out_d_valid),
        .in_ready  (bus.auto_out_d_ready),
        .in_bits   (d_in_bits),
        .out_valid (bus.auto_in_d_valid),
        .out_ready (bus.auto_in_d_ready),
        .out_bits  (d_out_bits)
    );
endmodule

// File: tb/tb_tl_buffer_ad.sv
// Directed bench for tl_buffer_ad: a default-depth instance and a depth-1 instance.
module tb_tl_buffer_ad;
    logic clock;
    logic reset;
    int   checks;
    int   failures;

    tl_buffer_ad_if bus2 ();
    tl_buffer_ad_if bus1 ();

    tl_buffer_ad #(.A_DEPTH(2), .D_DEPTH(2)) dut2 (.clock(clock), .reset(reset), .bus(bus2));
    tl_buffer_ad #(.A_DEPTH(1), .D_DEPTH(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Build a distinctive A beat: every field depends on n.
    function automatic logic [118:0] mk_a(input int n);
        logic [31:0] addr;
        addr = 32'h0000_2000 + 32'(n) * 32'd8;
        return {3'd4, 3'(n), 4'd3, 5'(n), addr[30:0], 8'(8'hF0 ^ n),
                64'hA5A5_0000_0000_0000 | 64'(n), 1'(n)};
    endfunction

    function automatic logic [80:0] mk_d(input int n);
        return {3'd1, 2'd2, 4'd3, 5'd7, 1'b1, 1'b0, 64'(n), 1'b0};
    endfunction

    task automatic drive_a2(input logic [118:0] b);
        {bus2.auto_in_a_bits_opcode, bus2.auto_in_a_bits_param, bus2.auto_in_a_bits_size,
         bus2.auto_in_a_bits_source, bus2.auto_in_a_bits_address, bus2.auto_in_a_bits_mask,
         bus2.auto_in_a_bits_data, bus2.auto_in_a_bits_corrupt} = b;
    endtask

    task automatic drive_a1(input logic [118:0] b);
        {bus1.auto_in_a_bits_opcode, bus1.auto_in_a_bits_param, bus1.auto_in_a_bits_size,
         bus1.auto_in_a_bits_source, bus1.auto_in_a_bits_address, bus1.auto_in_a_bits_mask,
         bus1.auto_in_a_bits_data, bus1.auto_in_a_bits_corrupt} = b;
    endtask

    task automatic drive_d2(input logic [80:0] b);
        {bus2.auto_out_d_bits_opcode, bus2.auto_out_d_bits_param, bus2.auto_out_d_bits_size,
         bus2.auto_out_d_bits_source, bus2.auto_out_d_bits_sink, bus2.auto_out_d_bits_denied,
         bus2.auto_out_d_bits_data, bus2.auto_out_d_bits_corrupt} = b;
    endtask

    function automatic logic [118:0] out_a2();
        return {bus2.auto_out_a_bits_opcode, bus2.auto_out_a_bits_param, bus2.auto_out_a_bits_size,
                bus2.auto_out_a_bits_source, bus2.auto_out_a_bits_address, bus2.auto_out_a_bits_mask,
                bus2.auto_out_a_bits_data, bus2.auto_out_a_bits_corrupt};
    endfunction

    function automatic logic [118:0] out_a1();
        return {bus1.auto_out_a_bits_opcode, bus1.auto_out_a_bits_param, bus1.auto_out_a_bits_size,
                bus1.auto_out_a_bits_source, bus1.auto_out_a_bits_address, bus1.auto_out_a_bits_mask,
                bus1.auto_out_a_bits_data, bus1.auto_out_a_bits_corrupt};
    endfunction

    function automatic logic [80:0] out_d2();
        return {bus2.auto_in_d_bits_opcode, bus2.auto_in_d_bits_param, bus2.auto_in_d_bits_size,
                bus2.auto_in_d_bits_source, bus2.auto_in_d_bits_sink, bus2.auto_in_d_bits_denied,
                bus2.auto_in_d_bits_data, bus2.auto_in_d_bits_corrupt};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks += 4;
        if (bus2.auto_out_a_valid !== 1'b0) begin failures++; $display("FAIL reset_out_a_valid actual=%b expected=0", bus2.auto_out_a_valid); end
        if (bus2.auto_in_d_valid !== 1'b0) begin failures++; $display("FAIL reset_in_d_valid actual=%b expected=0", bus2.auto_in_d_valid); end
        if (bus2.auto_in_a_ready !== 1'b1) begin failures++; $display("FAIL reset_in_a_ready actual=%b expected=1", bus2.auto_in_a_ready); end
        if (bus2.auto_out_d_ready !== 1'b1) begin failures++; $display("FAIL reset_out_d_ready actual=%b expected=1", bus2.auto_out_d_ready); end
        reset = 1'b1;
    endtask

    task automatic test_single_beat();
        logic [118:0] b;
        b = {3'd4, 3'd0, 4'd3, 5'd5, 31'h0000_1000, 8'hFF, 64'hDEAD_BEEF_0123_4567, 1'b1};
        drive_a2(b);
        bus2.auto_out_a_ready = 1'b1;
        bus2.auto_in_a_valid = 1'b1;
        checks++;
        if (bus2.auto_out_a_valid !== 1'b0) begin failures++; $display("FAIL single_no_flow actual=%b expected=0", bus2.auto_out_a_valid); end
        tick();
        bus2.auto_in_a_valid = 1'b0;
        drive_a2('0);
        checks += 2;
        if (bus2.auto_out_a_valid !== 1'b1) begin failures++; $display("FAIL single_valid actual=%b expected=1", bus2.auto_out_a_valid); end
        if (out_a2() !== b) begin failures++; $display("FAIL single_bits actual=%h expected=%h", out_a2(), b); end
        tick();
        checks++;
        if (bus2.auto_out_a_valid !== 1'b0) begin failures++; $display("FAIL single_valid_drop actual=%b expected=0", bus2.auto_out_a_valid); end
    endtask

    task automatic test_backpressure();
        bus2.auto_out_a_ready = 1'b0;
        bus2.auto_in_a_valid = 1'b1;
        drive_a2(mk_a(1));
        tick();
        checks++;
        if (bus2.auto_in_a_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after1 actual=%b expected=1", bus2.auto_in_a_ready); end
        drive_a2(mk_a(2));
        tick();
        checks++;
        if (bus2.auto_in_a_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_after2 actual=%b expected=0", bus2.auto_in_a_ready); end
        drive_a2(mk_a(3));
        tick();
        checks += 2;
        if (bus2.auto_in_a_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_held actual=%b expected=0", bus2.auto_in_a_ready); end
        if (out_a2() !== mk_a(1)) begin failures++; $display("FAIL bp_head_stable actual=%h expected=%h", out_a2(), mk_a(1)); end
        bus2.auto_out_a_ready = 1'b1;
        tick();
        checks += 2;
        if (out_a2() !== mk_a(2)) begin failures++; $display("FAIL bp_order2 actual=%h expected=%h", out_a2(), mk_a(2)); end
        if (bus2.auto_in_a_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_reopen actual=%b expected=1", bus2.auto_in_a_ready); end
        tick();
        bus2.auto_in_a_valid = 1'b0;
        checks += 2;
        if (bus2.auto_out_a_valid !== 1'b1) begin failures++; $display("FAIL bp_valid3 actual=%b expected=1", bus2.auto_out_a_valid); end
        if (out_a2() !== mk_a(3)) begin failures++; $display("FAIL bp_order3 actual=%h expected=%h", out_a2(), mk_a(3)); end
        tick();
        checks++;
        if (bus2.auto_out_a_valid !== 1'b0) begin failures++; $display("FAIL bp_drained actual=%b expected=0", bus2.auto_out_a_valid); end
    endtask

    task automatic test_full_dequeue();
        bus2.auto_out_a_ready = 1'b0;
        bus2.auto_in_a_valid = 1'b1;
        drive_a2(mk_a(10));
        tick();
        drive_a2(mk_a(11));
        tick();
        drive_a2(mk_a(12));
        bus2.auto_out_a_ready = 1'b1;
        checks++;
        if (bus2.auto_in_a_ready !== 1'b0) begin failures++; $display("FAIL full_deq_no_pipe actual=%b expected=0", bus2.auto_in_a_ready); end
        tick();
        bus2.auto_in_a_valid = 1'b0;
        bus2.auto_out_a_ready = 1'b0;
        checks += 3;
        if (bus2.auto_in_a_ready !== 1'b1) begin failures++; $display("FAIL full_deq_ready_next actual=%b expected=1", bus2.auto_in_a_ready); end
        if (bus2.auto_out_a_valid !== 1'b1) begin failures++; $display("FAIL full_deq_count1 actual=%b expected=1", bus2.auto_out_a_valid); end
        if (out_a2() !== mk_a(11)) begin failures++; $display("FAIL full_deq_head actual=%h expected=%h", out_a2(), mk_a(11)); end
        bus2.auto_out_a_ready = 1'b1;
        tick();
        checks++;
        if (bus2.auto_out_a_valid !== 1'b0) begin failures++; $display("FAIL full_deq_drain actual=%b expected=0", bus2.auto_out_a_valid); end
    endtask

    task automatic test_stream_d();
        bus2.auto_in_d_ready = 1'b1;
        bus2.auto_out_d_valid = 1'b1;
        drive_d2(mk_d(0));
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k < 16) begin
                drive_d2(mk_d(k));
            end else begin
                bus2.auto_out_d_valid = 1'b0;
                drive_d2('0);
            end
            if (k <= 16) begin
                checks += 3;
                if (bus2.auto_out_d_ready !== 1'b1) begin failures++; $display("FAIL stream_ready k=%0d actual=%b expected=1", k, bus2.auto_out_d_ready); end
                if (bus2.auto_in_d_valid !== 1'b1) begin failures++; $display("FAIL stream_valid k=%0d actual=%b expected=1", k, bus2.auto_in_d_valid); end
                if (out_d2() !== mk_d(k - 1)) begin failures++; $display("FAIL stream_data k=%0d actual=%h expected=%h", k, out_d2(), mk_d(k - 1)); end
            end else begin
                checks++;
                if (bus2.auto_in_d_valid !== 1'b0) begin failures++; $display("FAIL stream_end actual=%b expected=0", bus2.auto_in_d_valid); end
            end
        end
    endtask

    task automatic test_async_reset();
        bus2.auto_out_a_ready = 1'b0;
        bus2.auto_in_a_valid = 1'b1;
        drive_a2(mk_a(20));
        tick();
        drive_a2(mk_a(21));
        tick();
        bus2.auto_in_a_valid = 1'b0;
        checks++;
        if (bus2.auto_out_a_valid !== 1'b1) begin failures++; $display("FAIL areset_pre_valid actual=%b expected=1", bus2.auto_out_a_valid); end
        #2;
        reset = 1'b0;
        #1;
        checks += 2;
        if (bus2.auto_out_a_valid !== 1'b0) begin failures++; $display("FAIL areset_async_drop actual=%b expected=0", bus2.auto_out_a_valid); end
        if (bus2.auto_in_a_ready !== 1'b1) begin failures++; $display("FAIL areset_async_ready actual=%b expected=1", bus2.auto_in_a_ready); end
        tick();
        reset = 1'b1;
        bus2.auto_out_a_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks += 2;
            if (bus2.auto_out_a_valid !== 1'b0) begin failures++; $display("FAIL areset_stale k=%0d actual=%b expected=0", k, bus2.auto_out_a_valid); end
            if (bus2.auto_in_a_ready !== 1'b1) begin failures++; $display("FAIL areset_ready k=%0d actual=%b expected=1", k, bus2.auto_in_a_ready); end
        end
    endtask

    task automatic test_depth1();
        bus1.auto_out_a_ready = 1'b1;
        bus1.auto_in_a_valid = 1'b1;
        drive_a1(mk_a(1));
        for (int i = 1; i <= 8; i++) begin
            tick();
            drive_a1(mk_a(i / 2 + 1));
            checks += 2;
            if ((i % 2) == 1) begin
                if (bus1.auto_out_a_valid !== 1'b1) begin failures++; $display("FAIL d1_valid i=%0d actual=%b expected=1", i, bus1.auto_out_a_valid); end
                if (bus1.auto_in_a_ready !== 1'b0) begin failures++; $display("FAIL d1_ready i=%0d actual=%b expected=0", i, bus1.auto_in_a_ready); end
                checks++;
                if (out_a1() !== mk_a((i + 1) / 2)) begin failures++; $display("FAIL d1_order i=%0d actual=%h expected=%h", i, out_a1(), mk_a((i + 1) / 2)); end
            end else begin
                if (bus1.auto_out_a_valid !== 1'b0) begin failures++; $display("FAIL d1_valid i=%0d actual=%b expected=0", i, bus1.auto_out_a_valid); end
                if (bus1.auto_in_a_ready !== 1'b1) begin failures++; $display("FAIL d1_ready i=%0d actual=%b expected=1", i, bus1.auto_in_a_ready); end
            end
        end
        bus1.auto_in_a_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        bus2.auto_in_a_valid = 1'b0;
        bus2.auto_out_a_ready = 1'b0;
        bus2.auto_out_d_valid = 1'b0;
        bus2.auto_in_d_ready = 1'b1;
        bus1.auto_in_a_valid = 1'b0;
        bus1.auto_out_a_ready = 1'b0;
        bus1.auto_out_d_valid = 1'b0;
        bus1.auto_in_d_ready = 1'b1;
        drive_a2('0);
        drive_a1('0);
        drive_d2('0);
        {bus1.auto_out_d_bits_opcode, bus1.auto_out_d_bits_param, bus1.auto_out_d_bits_size,
         bus1.auto_out_d_bits_source, bus1.auto_out_d_bits_sink, bus1.auto_out_d_bits_denied,
         bus1.auto_out_d_bits_data, bus1.auto_out_d_bits_corrupt} = '0;

        test_reset();
        test_single_beat();
        test_backpressure();
        test_full_dequeue();
        test_stream_d();
        test_async_reset();
        test_depth1();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
